alu_controller: RTL and testbench
=================================

// Module: alu_controller
// PURPOSE
//  Multicycle fetch/decode/execute sequencer on the issuing side of the ALU interface.
//  Fetches 16-bit instructions and drives the ALU opcode and register-file read/write selects.
//  Captures the ALU {overflow, negative, zero} flags and resolves conditional branches on them.
//  Sits between the instruction memory, the register file and the alu datapath.
// PARAMETERS
//  BW  16  datapath width; width of the imm output
//  AW  8   program-counter / instruction-address width
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  start        in   1     one-cycle pulse; starts execution at address 0
//  instr_rdata  in   16    instruction word, valid the cycle after instr_req
//  alu_flags    in   3     {overflow, negative, zero} from the ALU for the current opcode
//  instr_req    out  1     instruction read strobe
//  pc_out       out  AW    instruction address, meaningful when instr_req=1
//  alu_opcode   out  4     ALU operation select
//  rf_ra        out  3     register-file read port A address
//  rf_rb        out  3     register-file read port B address
//  rf_wa        out  3     register-file write address
//  rf_we        out  1     register-file write enable; single cycle
//  wd_sel       out  1     write-data mux select: 0 = ALU out, 1 = imm
//  imm          out  BW    sign-extended immediate
//  flags_q      out  3     registered flags, {V,N,Z}
//  busy         out  1     high from FETCH through EXECUTE
//  halted       out  1     high in HALT
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, IR=0, flags_q=0. Every output is 0 while in reset and in IDLE.
//  Reset is asynchronous and overrides any operation in progress; no rf_we pulse is emitted after rst_n falls.
//  FSM: IDLE -start-> FETCH -> DECODE -> EXECUTE -> FETCH | HALT; HALT -start-> FETCH with pc=0.
//  start is ignored in FETCH, DECODE and EXECUTE.
//  FETCH: instr_req=1, pc_out=pc for exactly one cycle.
//  DECODE: IR <= instr_rdata.
//  EXECUTE: alu_opcode, rf_ra, rf_rb, rf_wa, wd_sel and imm are driven combinationally from IR.
//   Each instruction takes exactly 3 cycles.
//  Instruction format: IR[15:12]=op, IR[11:9]=rd, IR[8:6]=ra, IR[5:3]=rb.
//  op 0-7 (ADD, SUB, AND, OR, XOR, INC, PASSA, PASSB):
//   - alu_opcode=op, rf_we=1, wd_sel=0;
//   - flags_q <= alu_flags at the end of EXECUTE; pc <= pc+1.
//  op 8 LDI: imm = sign-extend(IR[8:0]) to BW; rf_wa=rd, wd_sel=1, rf_we=1.
//   flags_q unchanged; pc <= pc+1.
//  op 9 BRZ / 10 BRN / 11 BRV: if flags_q[0] / [1] / [2] is set, pc <= IR[AW-1:0]; else pc <= pc+1.
//   No register write.
//  op 12 JMP: pc <= IR[AW-1:0] unconditionally.
//  op 15 HALT: next state HALT; pc holds.
//  op 13, 14: NOP; pc <= pc+1.
//  Branch conditions use flags_q as registered before the branch, never the live alu_flags.
//  pc arithmetic is modulo 2^AW: pc = 2^AW-1 with a non-branch op wraps to 0.
//  Taken branch or JMP to its own address loops forever and is legal.
//  In DECODE, HALT and IDLE: alu_opcode=0, rf_we=0, instr_req=0.
// TESTING
//  1. Reset, then start; mem[0]=LDI r1,5 -> pc_out=0 at cycle 1; rf_we=1, wd_sel=1, imm=0x0005, rf_wa=1 at cycle 3.
//  2. LDI r1,-1; LDI r2,1; ADD r3,r1,r2
//     -> ADD EXECUTE: alu_opcode=0, ra=1, rb=2; alu_flags=001 latched, flags_q=001.
//  3. Then BRZ 0x20 -> next pc_out=0x20.
//     Repeat with flags_q=000 -> next pc_out = branch address + 1.
//  4. AW=8, JMP 0xFF where mem[0xFF]=NOP -> pc_out 0xFF, then 0x00.
//  5. HALT -> halted=1, busy=0; start 10 cycles later -> FETCH at pc_out=0.
//     start pulsed mid-DECODE is ignored.
//  6. rst_n low during EXECUTE of an ADD -> rf_we and all outputs 0 immediately; state IDLE.
//     flags_q=0 after release.

Source files
------------

// File: rtl/alu_controller.sv
// Multicycle fetch/decode/execute sequencer driving the ALU and register file.
// Each instruction takes three cycles: FETCH issues the read, DECODE latches
// the word into IR, EXECUTE drives the datapath selects and picks the next pc.
module alu_controller #(
    parameter int unsigned BW = 16,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   instr_rdata,
    input  logic [2:0]    alu_flags,
    output logic          instr_req,
    output logic [AW-1:0] pc_out,
    output logic [3:0]    alu_opcode,
    output logic [2:0]    rf_ra,
    output logic [2:0]    rf_rb,
    output logic [2:0]    rf_wa,
    output logic          rf_we,
    output logic          wd_sel,
    output logic [BW-1:0] imm,
    output logic [2:0]    flags_q,
    output logic          busy,
    output logic          halted
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StHalt
    } state_e;

    localparam logic [3:0] OpLdi  = 4'h8;
    localparam logic [3:0] OpBrz  = 4'h9;
    localparam logic [3:0] OpBrn  = 4'hA;
    localparam logic [3:0] OpBrv  = 4'hB;
    localparam logic [3:0] OpJmp  = 4'hC;
    localparam logic [3:0] OpHalt = 4'hF;

    state_e        state_q;
    logic [AW-1:0] pc_q;
    logic [15:0]   ir_q;
    logic          req_q;
    logic          busy_q;
    logic          halted_q;

    logic [3:0]    op;
    logic          is_alu;
    logic          is_ldi;
    logic          taken;
    logic [AW-1:0] pc_next;

    assign op     = ir_q[15:12];
    assign is_alu = ~op[3];
    assign is_ldi = (op == OpLdi);

    // Branch resolution uses the flags registered by earlier instructions only
    always_comb begin
        taken = 1'b0;
        case (op)
            OpBrz:   taken = flags_q[0];
            OpBrn:   taken = flags_q[1];
            OpBrv:   taken = flags_q[2];
            OpJmp:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // Next pc: HALT holds, taken branch/JMP loads the target, everything else increments
    always_comb begin
        if (op == OpHalt) begin
            pc_next = pc_q;
        end else if (taken) begin
            pc_next = ir_q[AW-1:0];
        end else begin
            pc_next = pc_q + AW'(1);
        end
    end

    // Sequencer state, program counter, IR, flags and the registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            ir_q     <= '0;
            flags_q  <= '0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StHalt: begin
                    if (start) begin
                        state_q  <= StFetch;
                        pc_q     <= '0;
                        req_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                StFetch: begin
                    state_q <= StDecode;
                    req_q   <= 1'b0;
                end
                StDecode: begin
                    state_q <= StExecute;
                    ir_q    <= instr_rdata;
                end
                StExecute: begin
                    if (is_alu) begin
                        flags_q <= alu_flags;
                    end
                    if (op == OpHalt) begin
                        state_q  <= StHalt;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= StFetch;
                        req_q   <= 1'b1;
                        pc_q    <= pc_next;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    req_q    <= 1'b0;
                    busy_q   <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // Datapath selects decoded from IR, only asserted during EXECUTE
    always_comb begin
        alu_opcode = '0;
        rf_ra      = '0;
        rf_rb      = '0;
        rf_wa      = '0;
        rf_we      = 1'b0;
        wd_sel     = 1'b0;
        imm        = '0;
        if (state_q == StExecute) begin
            if (is_alu) begin
                alu_opcode = op;
                rf_ra      = ir_q[8:6];
                rf_rb      = ir_q[5:3];
                rf_wa      = ir_q[11:9];
                rf_we      = 1'b1;
            end else if (is_ldi) begin
                rf_wa  = ir_q[11:9];
                rf_we  = 1'b1;
                wd_sel = 1'b1;
                imm    = {{(BW - 9){ir_q[8]}}, ir_q[8:0]};
            end
        end
    end

    assign instr_req = req_q;
    assign pc_out    = req_q ? pc_q : '0;
    assign busy      = busy_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_alu_controller.sv
// Scoreboard bench for alu_controller: an instruction-level program model fills
// queues of expected fetches and register writes; a monitor checks them as the
// DUT presents instr_req / rf_we.
module tb_alu_controller;

    localparam int BW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   instr_rdata = '0;
    logic [2:0]    alu_flags = '0;
    logic          instr_req;
    logic [AW-1:0] pc_out;
    logic [3:0]    alu_opcode;
    logic [2:0]    rf_ra;
    logic [2:0]    rf_rb;
    logic [2:0]    rf_wa;
    logic          rf_we;
    logic          wd_sel;
    logic [BW-1:0] imm;
    logic [2:0]    flags_q;
    logic          busy;
    logic          halted;

    alu_controller #(.BW(BW), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instr_rdata (instr_rdata),
        .alu_flags   (alu_flags),
        .instr_req   (instr_req),
        .pc_out      (pc_out),
        .alu_opcode  (alu_opcode),
        .rf_ra       (rf_ra),
        .rf_rb       (rf_rb),
        .rf_wa       (rf_wa),
        .rf_we       (rf_we),
        .wd_sel      (wd_sel),
        .imm         (imm),
        .flags_q     (flags_q),
        .busy        (busy),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [2:0]    fl;
    } fetch_t;

    typedef struct packed {
        logic          ldi;
        logic [3:0]    opc;
        logic [2:0]    ra;
        logic [2:0]    rb;
        logic [2:0]    wa;
        logic [BW-1:0] imm;
    } wr_t;

    fetch_t      fetch_q[$];
    wr_t         wr_q[$];
    logic [15:0] mem      [256];
    logic [2:0]  flag_tab [256];
    logic [2:0]  model_fl = '0;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          checking = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory and ALU stand-in: data and flags follow the fetched address
    always @(negedge clk) begin
        if (instr_req) begin
            instr_rdata = mem[pc_out];
            alu_flags   = flag_tab[pc_out];
        end
    end

    // Monitor: pop and compare whenever the DUT fetches or writes
    always @(negedge clk) begin : monitor
        fetch_t f;
        wr_t    w;
        if (checking) begin
            if (instr_req) begin
                if (fetch_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL fetch_unexpected: got pc_out 0x%0h, expected no fetch", pc_out);
                end else begin
                    f = fetch_q.pop_front();
                    check("pc_out", pc_out, f.pc);
                    check("flags_q_at_fetch", flags_q, f.fl);
                    check("busy_at_fetch", busy, 1);
                end
            end
            if (rf_we) begin
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL write_unexpected: got rf_we to r%0d, expected no write", rf_wa);
                end else begin
                    w = wr_q.pop_front();
                    check("rf_wa", rf_wa, w.wa);
                    check("wd_sel", wd_sel, w.ldi);
                    if (w.ldi) begin
                        check("imm", imm, w.imm);
                    end else begin
                        check("alu_opcode", alu_opcode, w.opc);
                        check("rf_ra", rf_ra, w.ra);
                        check("rf_rb", rf_rb, w.rb);
                    end
                end
            end
        end
    end

    // Instruction-level model: walks the program from address 0 for up to k instructions
    task automatic run_model(input int k, output int n, output bit h);
        int     pc;
        int     op;
        int     v;
        bit     cond;
        logic [15:0] w;
        fetch_t f;
        wr_t    r;
        pc = 0;
        n  = 0;
        h  = 1'b0;
        while (n < k && !h) begin
            w  = mem[pc];
            op = int'(w[15:12]);
            n++;
            f.pc = pc[AW-1:0];
            f.fl = model_fl;
            fetch_q.push_back(f);
            if (op <= 7) begin
                r.ldi = 1'b0;
                r.opc = w[15:12];
                r.wa  = w[11:9];
                r.ra  = w[8:6];
                r.rb  = w[5:3];
                r.imm = '0;
                wr_q.push_back(r);
                model_fl = flag_tab[pc];
                pc = (pc + 1) % 256;
            end else if (op == 8) begin
                v = int'(w[8:0]);
                if (v >= 256) v = v - 512;
                r.ldi = 1'b1;
                r.opc = '0;
                r.wa  = w[11:9];
                r.ra  = '0;
                r.rb  = '0;
                r.imm = v[BW-1:0];
                wr_q.push_back(r);
                pc = (pc + 1) % 256;
            end else if (op >= 9 && op <= 11) begin
                cond = model_fl[op - 9];
                pc = cond ? int'(w[7:0]) : (pc + 1) % 256;
            end else if (op == 12) begin
                pc = int'(w[7:0]);
            end else if (op == 15) begin
                h = 1'b1;
            end else begin
                pc = (pc + 1) % 256;
            end
        end
    endtask

    // Start the DUT (plus an ignored start during the first DECODE) and let it run n instructions
    task automatic run_prog(input int k, output bit h);
        int n;
        run_model(k, n, h);
        checking = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3 * n - 3) @(negedge clk);
        @(posedge clk);
        #1;
        checking = 1'b0;
        check("fetch_q_drained", fetch_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
        fetch_q.delete();
        wr_q.delete();
        if (h) begin
            check("halted", halted, 1);
            check("busy_in_halt", busy, 0);
            check("instr_req_in_halt", instr_req, 0);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        model_fl = '0;
        repeat (2) @(negedge clk);
        check("outputs_in_reset",
              {instr_req, pc_out, alu_opcode, rf_ra, rf_rb, rf_wa, rf_we, wd_sel, imm,
               flags_q, busy, halted}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("outputs_idle",
              {instr_req, pc_out, alu_opcode, rf_ra, rf_rb, rf_wa, rf_we, wd_sel, imm,
               flags_q, busy, halted}, 0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i]      = 16'hF000;
            flag_tab[i] = '0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        clear_mem();
        do_reset();

        // LDI r1,5; LDI r1,-1; LDI r2,1; ADD r3,r1,r2 (Z set); BRZ 0x20 taken;
        // ADD r4,r1,r1 (flags clear); BRZ 0x40 not taken; HALT at 0x22
        mem[0]        = {4'h8, 3'd1, 9'd5};
        mem[1]        = {4'h8, 3'd1, 9'h1FF};
        mem[2]        = {4'h8, 3'd2, 9'd1};
        mem[3]        = {4'h0, 3'd3, 3'd1, 3'd2, 3'd0};
        flag_tab[3]   = 3'b001;
        mem[4]        = {4'h9, 4'h0, 8'h20};
        mem[8'h20]    = {4'h0, 3'd4, 3'd1, 3'd1, 3'd0};
        flag_tab[8'h20] = 3'b000;
        mem[8'h21]    = {4'h9, 4'h0, 8'h40};
        run_prog(20, h);

        // Restart from HALT after a pause: fetch must begin again at 0
        repeat (10) @(negedge clk);
        run_prog(20, h);

        // JMP to the top address, then wrap from 0xFF to 0x00
        do_reset();
        clear_mem();
        mem[0]   = {4'hC, 4'h0, 8'hFF};
        mem[255] = 16'hD000;
        run_prog(7, h);

        // Reset asserted during EXECUTE of a SUB
        do_reset();
        clear_mem();
        mem[0]      = {4'h1, 3'd3, 3'd1, 3'd2, 3'd0};
        mem[1]      = {4'h1, 3'd3, 3'd1, 3'd2, 3'd0};
        flag_tab[0] = 3'b111;
        flag_tab[1] = 3'b010;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (5) @(negedge clk);
        check("rf_we_before_reset", rf_we, 1);
        check("flags_q_before_reset", flags_q, 3'b111);
        check("alu_opcode_before_reset", alu_opcode, 4'h1);
        #2 rst_n = 1'b0;
        model_fl = '0;
        #1;
        check("outputs_async_reset",
              {instr_req, pc_out, alu_opcode, rf_ra, rf_rb, rf_wa, rf_we, wd_sel, imm,
               flags_q, busy, halted}, 0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("flags_q_after_release", flags_q, 0);
        check("busy_after_release", busy, 0);
        check("instr_req_after_release", instr_req, 0);

        // Random programs against the model
        for (int p = 0; p < 25; p++) begin
            do_reset();
            for (int i = 0; i < 256; i++) begin
                mem[i]      = 16'($urandom);
                flag_tab[i] = 3'($urandom);
            end
            run_prog(30, h);
        end
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
